// File: rtl/ahb_decoder_pl.sv
// AHB-Lite address decoder with registered data-phase mux select and integrated default slave.
// Latency: HSEL/HSEL_NOMAP combinational; MUX_SEL, default-slave response and fault capture one cycle.
// Backpressure: MUX_SEL holds while HREADY=0; a fault only starts an ERROR response when HREADY=1.
module ahb_decoder_pl #(
  parameter int                      NUM_SLAVES = 10,
  parameter logic [NUM_SLAVES*8-1:0] SLV_BASE   = {8'h57, 8'h56, 8'h55, 8'h54, 8'h53,
                                                   8'h52, 8'h51, 8'h50, 8'h20, 8'h00},
  parameter int                      ERR_CNT_W  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic                  FAULT_CLR,
  output logic [NUM_SLAVES-1:0] HSEL,
  output logic                  HSEL_NOMAP,
  output logic [3:0]            MUX_SEL,
  output logic                  DFLT_HREADYOUT,
  output logic                  DFLT_HRESP,
  output logic [31:0]           FAULT_ADDR,
  output logic [ERR_CNT_W-1:0]  FAULT_CNT
);

  // Slave numbers are carried in 4 bits with 15 reserved for the default slave.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 15) begin : g_bad_num_slaves
    $error("ahb_decoder_pl: NUM_SLAVES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } dflt_state_t;

  localparam logic [3:0] DFLT_IDX = 4'd15;

  dflt_state_t state;
  logic        hit;
  logic [3:0]  hit_idx;
  logic        fault;
  logic        capture;
  logic [ERR_CNT_W-1:0] cnt_inc;

  // Transfer type bit 0 (SEQ vs NONSEQ, IDLE vs BUSY) does not affect decoding.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Priority decode: the lowest matching index wins so duplicated bases stay one-hot.
  always_comb begin
    HSEL    = '0;
    hit     = 1'b0;
    hit_idx = DFLT_IDX;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && (HADDR[31:24] == SLV_BASE[i*8 +: 8])) begin
        hit     = 1'b1;
        HSEL[i] = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  assign HSEL_NOMAP = ~|HSEL;

  // Only active transfers accepted on the bus can fault; IDLE/BUSY to holes get OKAY.
  assign fault   = HREADY & HSEL_NOMAP & HTRANS[1];
  // ERR1 is the wait-state cycle of the response, so no new address phase completes there.
  assign capture = fault & (state != ERR1);

  assign cnt_inc = (FAULT_CNT == '1) ? FAULT_CNT : FAULT_CNT + 1'b1;

  // Data-phase mux select advances only when the previous data phase completes.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      MUX_SEL <= DFLT_IDX;
    end else if (HREADY) begin
      MUX_SEL <= hit_idx;
    end
  end

  // Default slave: two-cycle ERROR response with registered HREADYOUT/HRESP.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state          <= IDLE;
      DFLT_HREADYOUT <= 1'b1;
      DFLT_HRESP     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fault) begin
            state          <= ERR1;
            DFLT_HREADYOUT <= 1'b0;
            DFLT_HRESP     <= 1'b1;
          end
        end
        ERR1: begin
          state          <= ERR2;
          DFLT_HREADYOUT <= 1'b1;
          DFLT_HRESP     <= 1'b1;
        end
        ERR2: begin
          if (fault) begin
            state          <= ERR1;
            DFLT_HREADYOUT <= 1'b0;
            DFLT_HRESP     <= 1'b1;
          end else begin
            state          <= IDLE;
            DFLT_HREADYOUT <= 1'b1;
            DFLT_HRESP     <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          DFLT_HREADYOUT <= 1'b1;
          DFLT_HRESP     <= 1'b0;
        end
      endcase
    end
  end

  // Fault capture for debug firmware; a new fault outranks a same-cycle clear.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      FAULT_ADDR <= '0;
      FAULT_CNT  <= '0;
    end else if (capture) begin
      FAULT_ADDR <= HADDR;
      FAULT_CNT  <= FAULT_CLR ? ERR_CNT_W'(1) : cnt_inc;
    end else if (FAULT_CLR) begin
      FAULT_ADDR <= '0;
      FAULT_CNT  <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_decoder_pl.sv
// Self-checking bench for ahb_decoder_pl: directed scenarios plus randomized traffic.
// A default-width DUT and an ERR_CNT_W=2 DUT share stimulus; a behavioural model predicts both.
module tb_ahb_decoder_pl;

  logic        hclk;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        fault_clr;

  logic [9:0]  hsel;
  logic        hsel_nomap;
  logic [3:0]  mux_sel;
  logic        dflt_hreadyout;
  logic        dflt_hresp;
  logic [31:0] fault_addr;
  logic [7:0]  fault_cnt;

  logic [9:0]  hsel_b;
  logic        hsel_nomap_b;
  logic [3:0]  mux_sel_b;
  logic        dflt_hreadyout_b;
  logic        dflt_hresp_b;
  logic [31:0] fault_addr_b;
  logic [1:0]  fault_cnt_b;

  int errors = 0;
  int checks = 0;

  // Memory map as the system sees it: slave i answers at HADDR[31:24] == map_base[i].
  logic [7:0] map_base [10] = '{8'h00, 8'h20, 8'h50, 8'h51, 8'h52,
                                8'h53, 8'h54, 8'h55, 8'h56, 8'h57};

  // Behavioural model state.
  int          m_mux;      // data-phase slave number, 15 = default slave
  int          m_resp_cyc; // 0 = no error response, 1/2 = first/second ERROR cycle
  logic [31:0] m_faddr;
  int          m_cnt8;
  int          m_cnt2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  ahb_decoder_pl u_dut (
    .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans), .HREADY(hready),
    .FAULT_CLR(fault_clr), .HSEL(hsel), .HSEL_NOMAP(hsel_nomap), .MUX_SEL(mux_sel),
    .DFLT_HREADYOUT(dflt_hreadyout), .DFLT_HRESP(dflt_hresp),
    .FAULT_ADDR(fault_addr), .FAULT_CNT(fault_cnt)
  );

  ahb_decoder_pl #(.ERR_CNT_W(2)) u_dut_w2 (
    .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans), .HREADY(hready),
    .FAULT_CLR(fault_clr), .HSEL(hsel_b), .HSEL_NOMAP(hsel_nomap_b), .MUX_SEL(mux_sel_b),
    .DFLT_HREADYOUT(dflt_hreadyout_b), .DFLT_HRESP(dflt_hresp_b),
    .FAULT_ADDR(fault_addr_b), .FAULT_CNT(fault_cnt_b)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Which slave owns an address: first match in the map, -1 for a hole.
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < 10; i++) begin
      if (map_base[i] == a[31:24]) return i;
    end
    return -1;
  endfunction

  function automatic logic [9:0] ref_hsel(input logic [31:0] a);
    logic [9:0] v;
    int s;
    v = '0;
    s = ref_slave(a);
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic tick();
    int s;
    bit starts_error;
    s = ref_slave(haddr);
    if (!hresetn) begin
      m_mux = 15; m_resp_cyc = 0; m_faddr = '0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      starts_error = hready && (s < 0) && htrans[1] && (m_resp_cyc != 1);
      if (hready) m_mux = (s < 0) ? 15 : s;
      if (m_resp_cyc == 1)   m_resp_cyc = 2;
      else if (starts_error) m_resp_cyc = 1;
      else                   m_resp_cyc = 0;
      if (starts_error) begin
        m_faddr = haddr;
        m_cnt8  = fault_clr ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
        m_cnt2  = fault_clr ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
      end else if (fault_clr) begin
        m_faddr = '0; m_cnt8 = 0; m_cnt2 = 0;
      end
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; haddr = 32'h9000_0000; htrans = T_NONSEQ; hready = 1'b1; fault_clr = 1'b0;
    tick();
    tick();
    checks++; if (mux_sel !== 4'd15) begin errors++; $display("FAIL reset_mux_sel got %0d want 15", mux_sel); end
    checks++; if (dflt_hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b want 1", dflt_hreadyout); end
    checks++; if (dflt_hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b want 0", dflt_hresp); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL reset_fault_cnt got %0d want 0", fault_cnt); end
    checks++; if (fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault_addr got %h want 0", fault_addr); end
    checks++; if (hsel_nomap !== 1'b1 || hsel !== 10'b0) begin
      errors++; $display("FAIL reset_decode got hsel=%b nomap=%b want 0/1", hsel, hsel_nomap);
    end
  endtask

  task automatic test_mapped();
    hresetn = 1'b1; haddr = 32'h5100_0004; htrans = T_NONSEQ; hready = 1'b1;
    #1;
    checks++; if (hsel !== 10'b0000001000) begin errors++; $display("FAIL mapped_hsel got %b want 0000001000", hsel); end
    tick();
    checks++; if (mux_sel !== 4'd3) begin errors++; $display("FAIL mapped_mux_sel got %0d want 3", mux_sel); end
    checks++; if (dflt_hreadyout !== 1'b1 || dflt_hresp !== 1'b0) begin
      errors++; $display("FAIL mapped_dflt got %b/%b want 1/0", dflt_hreadyout, dflt_hresp);
    end
  endtask

  task automatic test_unmapped();
    haddr = 32'h9000_0010; htrans = T_NONSEQ; hready = 1'b1;
    #1;
    checks++; if (hsel_nomap !== 1'b1) begin errors++; $display("FAIL unmapped_nomap got %b want 1", hsel_nomap); end
    tick();
    checks++; if (dflt_hreadyout !== 1'b0 || dflt_hresp !== 1'b1) begin
      errors++; $display("FAIL unmapped_err1 got %b/%b want 0/1", dflt_hreadyout, dflt_hresp);
    end
    checks++; if (mux_sel !== 4'd15) begin errors++; $display("FAIL unmapped_mux_sel got %0d want 15", mux_sel); end
    htrans = T_IDLE; hready = 1'b0;
    tick();
    checks++; if (dflt_hreadyout !== 1'b1 || dflt_hresp !== 1'b1) begin
      errors++; $display("FAIL unmapped_err2 got %b/%b want 1/1", dflt_hreadyout, dflt_hresp);
    end
    hready = 1'b1;
    tick();
    checks++; if (dflt_hreadyout !== 1'b1 || dflt_hresp !== 1'b0) begin
      errors++; $display("FAIL unmapped_idle got %b/%b want 1/0", dflt_hreadyout, dflt_hresp);
    end
    checks++; if (fault_addr !== 32'h9000_0010) begin errors++; $display("FAIL unmapped_fault_addr got %h want 90000010", fault_addr); end
    checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL unmapped_fault_cnt got %0d want 1", fault_cnt); end
  endtask

  task automatic test_idle_unmapped();
    haddr = 32'h9000_0000; htrans = T_IDLE; hready = 1'b1;
    tick();
    checks++; if (mux_sel !== 4'd15) begin errors++; $display("FAIL idle_mux_sel got %0d want 15", mux_sel); end
    checks++; if (dflt_hreadyout !== 1'b1 || dflt_hresp !== 1'b0) begin
      errors++; $display("FAIL idle_dflt got %b/%b want 1/0", dflt_hreadyout, dflt_hresp);
    end
    checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL idle_fault_cnt got %0d want 1", fault_cnt); end
  endtask

  task automatic test_wait_hold();
    haddr = 32'h2000_0000; htrans = T_NONSEQ; hready = 1'b1;
    tick();
    checks++; if (mux_sel !== 4'd1) begin errors++; $display("FAIL hold_first got %0d want 1", mux_sel); end
    haddr = 32'h5200_0000; hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (mux_sel !== 4'd1) begin errors++; $display("FAIL hold_wait%0d got %0d want 1", k, mux_sel); end
    end
    hready = 1'b1;
    tick();
    checks++; if (mux_sel !== 4'd4) begin errors++; $display("FAIL hold_release got %0d want 4", mux_sel); end
  endtask

  task automatic test_back_to_back();
    // Clear the counters first with a mapped access in flight.
    haddr = 32'h5000_0000; htrans = T_NONSEQ; hready = 1'b1; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault_cnt_b !== 2'd0 || fault_addr_b !== 32'h0) begin
      errors++; $display("FAIL b2b_clear got cnt=%0d addr=%h want 0/0", fault_cnt_b, fault_addr_b);
    end
    // Priming fault from IDLE, then four faults each issued in ERR2.
    for (int k = 0; k < 5; k++) begin
      haddr = 32'h9100_0000 + (k << 24) + k * 4; htrans = T_NONSEQ; hready = 1'b1;
      tick();
      checks++; if (dflt_hreadyout_b !== 1'b0 || dflt_hresp_b !== 1'b1) begin
        errors++; $display("FAIL b2b_err1_%0d got %b/%b want 0/1", k, dflt_hreadyout_b, dflt_hresp_b);
      end
      checks++; if (fault_cnt_b !== 2'((k + 1 > 3) ? 3 : k + 1)) begin
        errors++; $display("FAIL b2b_cnt_%0d got %0d want %0d", k, fault_cnt_b, (k + 1 > 3) ? 3 : k + 1);
      end
      htrans = T_IDLE; hready = 1'b0;
      tick();
      checks++; if (dflt_hreadyout_b !== 1'b1 || dflt_hresp_b !== 1'b1) begin
        errors++; $display("FAIL b2b_err2_%0d got %b/%b want 1/1", k, dflt_hreadyout_b, dflt_hresp_b);
      end
    end
    // Fault and clear in the same cycle: capture wins.
    haddr = 32'hA000_00F0; htrans = T_NONSEQ; hready = 1'b1; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault_cnt_b !== 2'd1) begin errors++; $display("FAIL b2b_clr_cnt got %0d want 1", fault_cnt_b); end
    checks++; if (fault_addr_b !== 32'hA000_00F0) begin errors++; $display("FAIL b2b_clr_addr got %h want a00000f0", fault_addr_b); end
    checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL b2b_clr_cnt8 got %0d want 1", fault_cnt); end
    htrans = T_IDLE; hready = 1'b0;
    tick();
    hready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [9:0]  exp_hsel;
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 1) r[31:24] = map_base[$urandom_range(0, 9)];
      haddr     = r;
      htrans    = 2'($urandom_range(0, 3));
      hready    = ($urandom_range(0, 3) != 0);
      fault_clr = ($urandom_range(0, 19) == 0);
      hresetn   = ($urandom_range(0, 49) != 0);
      #1;
      exp_hsel = ref_hsel(haddr);
      checks++; if (hsel !== exp_hsel || hsel_nomap !== (exp_hsel == 10'b0)) begin
        errors++; $display("FAIL rnd_decode n=%0d addr=%h got %b/%b want %b", n, haddr, hsel, hsel_nomap, exp_hsel);
      end
      tick();
      checks++; if (mux_sel !== 4'(m_mux)) begin
        errors++; $display("FAIL rnd_mux_sel n=%0d got %0d want %0d", n, mux_sel, m_mux);
      end
      checks++; if (dflt_hreadyout !== (m_resp_cyc != 1) || dflt_hresp !== (m_resp_cyc != 0)) begin
        errors++; $display("FAIL rnd_dflt n=%0d got %b/%b want resp cycle %0d", n, dflt_hreadyout, dflt_hresp, m_resp_cyc);
      end
      checks++; if (fault_addr !== m_faddr || fault_cnt !== 8'(m_cnt8)) begin
        errors++; $display("FAIL rnd_fault n=%0d got %h/%0d want %h/%0d", n, fault_addr, fault_cnt, m_faddr, m_cnt8);
      end
      checks++; if (fault_cnt_b !== 2'(m_cnt2) || fault_addr_b !== m_faddr) begin
        errors++; $display("FAIL rnd_fault_w2 n=%0d got %h/%0d want %h/%0d", n, fault_addr_b, fault_cnt_b, m_faddr, m_cnt2);
      end
    end
  endtask

  initial begin
    m_mux = 15; m_resp_cyc = 0; m_faddr = '0; m_cnt8 = 0; m_cnt2 = 0;
    test_reset();
    test_mapped();
    test_unmapped();
    test_idle_unmapped();
    test_wait_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
